// File: rtl/traffic_lamp_guard.sv
// traffic_lamp_guard
// Safety stage behind the traffic-light state machine. It registers the lamp
// requests and uses them to drive the lamps. It rejects requests that are not
// one-hot, that step out of order, or that change a lamp too early. On a
// violation it latches a fault code and flashes yellow. The fault stays until
// an operator clear is accepted while red alone is requested, followed by a
// red-only recovery window.
module traffic_lamp_guard #(
    parameter int MIN_DWELL  = 4,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       red_in,
    input  logic       yellow_in,
    input  logic       green_in,
    input  logic       fault_clear,
    output logic       red_out,
    output logic       yellow_out,
    output logic       green_out,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL);
    localparam logic [DW-1:0] CNT_ONE    = DW'(1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
    localparam logic [FW-1:0] FLASH_ONE  = FW'(1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_PATTERN = 2'b01;
    localparam logic [1:0] CODE_SEQ     = 2'b10;
    localparam logic [1:0] CODE_DWELL   = 2'b11;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_FAULT   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LAMP_RED    = 2'd0,
        LAMP_GREEN  = 2'd1,
        LAMP_YELLOW = 2'd2
    } lamp_t;

    // Request vector ordering is {red, yellow, green}.
    function automatic logic is_one_hot(input logic [2:0] req);
        logic result;
        case (req)
            3'b100, 3'b010, 3'b001: result = 1'b1;
            default:                result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic lamp_t lamp_of(input logic [2:0] req);
        lamp_t result;
        case (req)
            3'b010:  result = LAMP_YELLOW;
            3'b001:  result = LAMP_GREEN;
            default: result = LAMP_RED;
        endcase
        return result;
    endfunction

    // The only legal changes are R->G, G->Y and Y->R.
    function automatic logic step_is_legal(input lamp_t from_lamp, input lamp_t to_lamp);
        logic result;
        case (from_lamp)
            LAMP_RED:    result = (to_lamp == LAMP_GREEN);
            LAMP_GREEN:  result = (to_lamp == LAMP_YELLOW);
            LAMP_YELLOW: result = (to_lamp == LAMP_RED);
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

    state_t        state_r,      state_nxt_s;
    lamp_t         acc_lamp_r,   acc_lamp_nxt_s;
    logic [DW-1:0] dwell_cnt_r,  dwell_cnt_nxt_s;
    logic [DW-1:0] rec_cnt_r,    rec_cnt_nxt_s;
    logic [FW-1:0] flash_cnt_r,  flash_cnt_nxt_s;
    logic          red_r,        red_nxt_s;
    logic          yellow_r,     yellow_nxt_s;
    logic          green_r,      green_nxt_s;
    logic          fault_r,      fault_nxt_s;
    logic [1:0]    code_r,       code_nxt_s;

    logic [2:0]    req_s;
    logic          red_only_s;
    lamp_t         in_lamp_s;
    logic [1:0]    viol_code_s;

    assign req_s      = {red_in, yellow_in, green_in};
    assign red_only_s = (req_s == 3'b100);
    assign in_lamp_s  = lamp_of(req_s);

    assign red_out    = red_r;
    assign yellow_out = yellow_r;
    assign green_out  = green_r;
    assign fault      = fault_r;
    assign fault_code = code_r;

    // Classify the current request. Only the highest-priority violation is reported.
    always_comb begin
        viol_code_s = CODE_NONE;
        if (!is_one_hot(req_s)) begin
            viol_code_s = CODE_PATTERN;
        end else if (in_lamp_s == acc_lamp_r) begin
            viol_code_s = CODE_NONE;
        end else if (!step_is_legal(acc_lamp_r, in_lamp_s)) begin
            viol_code_s = CODE_SEQ;
        end else if (dwell_cnt_r < DWELL_MAX) begin
            viol_code_s = CODE_DWELL;
        end else begin
            viol_code_s = CODE_NONE;
        end
    end

    // Next-state and next-output logic for NORMAL / FAULT / RECOVER.
    always_comb begin
        state_nxt_s     = state_r;
        acc_lamp_nxt_s  = acc_lamp_r;
        dwell_cnt_nxt_s = dwell_cnt_r;
        rec_cnt_nxt_s   = rec_cnt_r;
        flash_cnt_nxt_s = flash_cnt_r;
        red_nxt_s       = red_r;
        yellow_nxt_s    = yellow_r;
        green_nxt_s     = green_r;
        fault_nxt_s     = fault_r;
        code_nxt_s      = code_r;

        case (state_r)
            ST_NORMAL: begin
                if (viol_code_s != CODE_NONE) begin
                    state_nxt_s     = ST_FAULT;
                    fault_nxt_s     = 1'b1;
                    code_nxt_s      = viol_code_s;
                    red_nxt_s       = 1'b0;
                    yellow_nxt_s    = 1'b1;
                    green_nxt_s     = 1'b0;
                    flash_cnt_nxt_s = '0;
                end else begin
                    red_nxt_s    = red_in;
                    yellow_nxt_s = yellow_in;
                    green_nxt_s  = green_in;
                    fault_nxt_s  = 1'b0;
                    code_nxt_s   = CODE_NONE;
                    if (in_lamp_s == acc_lamp_r) begin
                        if (dwell_cnt_r < DWELL_MAX) begin
                            dwell_cnt_nxt_s = dwell_cnt_r + CNT_ONE;
                        end else begin
                            dwell_cnt_nxt_s = DWELL_MAX;
                        end
                    end else begin
                        acc_lamp_nxt_s  = in_lamp_s;
                        dwell_cnt_nxt_s = CNT_ONE;
                    end
                end
            end

            ST_FAULT: begin
                red_nxt_s   = 1'b0;
                green_nxt_s = 1'b0;
                if (fault_clear && red_only_s) begin
                    state_nxt_s   = ST_RECOVER;
                    fault_nxt_s   = 1'b0;
                    code_nxt_s    = CODE_NONE;
                    red_nxt_s     = 1'b1;
                    yellow_nxt_s  = 1'b0;
                    rec_cnt_nxt_s = CNT_ONE;
                end else if (flash_cnt_r == FLASH_LAST) begin
                    flash_cnt_nxt_s = '0;
                    yellow_nxt_s    = ~yellow_r;
                end else begin
                    flash_cnt_nxt_s = flash_cnt_r + FLASH_ONE;
                end
            end

            ST_RECOVER: begin
                red_nxt_s    = 1'b1;
                yellow_nxt_s = 1'b0;
                green_nxt_s  = 1'b0;
                if (!red_only_s) begin
                    state_nxt_s     = ST_FAULT;
                    fault_nxt_s     = 1'b1;
                    code_nxt_s      = CODE_DWELL;
                    red_nxt_s       = 1'b0;
                    yellow_nxt_s    = 1'b1;
                    flash_cnt_nxt_s = '0;
                end else if (rec_cnt_r == DWELL_MAX) begin
                    state_nxt_s     = ST_NORMAL;
                    acc_lamp_nxt_s  = LAMP_RED;
                    dwell_cnt_nxt_s = DWELL_MAX;
                end else begin
                    rec_cnt_nxt_s = rec_cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_nxt_s     = ST_NORMAL;
                acc_lamp_nxt_s  = LAMP_RED;
                dwell_cnt_nxt_s = DWELL_MAX;
                rec_cnt_nxt_s   = '0;
                flash_cnt_nxt_s = '0;
                red_nxt_s       = 1'b1;
                yellow_nxt_s    = 1'b0;
                green_nxt_s     = 1'b0;
                fault_nxt_s     = 1'b0;
                code_nxt_s      = CODE_NONE;
            end
        endcase
    end

    // State, counter and lamp registers. Reset selects steady red, with a change allowed at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_NORMAL;
            acc_lamp_r  <= LAMP_RED;
            dwell_cnt_r <= DWELL_MAX;
            rec_cnt_r   <= '0;
            flash_cnt_r <= '0;
            red_r       <= 1'b1;
            yellow_r    <= 1'b0;
            green_r     <= 1'b0;
            fault_r     <= 1'b0;
            code_r      <= CODE_NONE;
        end else begin
            state_r     <= state_nxt_s;
            acc_lamp_r  <= acc_lamp_nxt_s;
            dwell_cnt_r <= dwell_cnt_nxt_s;
            rec_cnt_r   <= rec_cnt_nxt_s;
            flash_cnt_r <= flash_cnt_nxt_s;
            red_r       <= red_nxt_s;
            yellow_r    <= yellow_nxt_s;
            green_r     <= green_nxt_s;
            fault_r     <= fault_nxt_s;
            code_r      <= code_nxt_s;
        end
    end

endmodule

// File: tb/tb_traffic_lamp_guard.sv
// Directed testbench for traffic_lamp_guard (MIN_DWELL=4, FLASH_HALF=3).
// Each observation is packed as {fault, fault_code[1:0], red, yellow, green}.
module tb_traffic_lamp_guard;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       red_in;
    logic       yellow_in;
    logic       green_in;
    logic       fault_clear;
    logic       red_out;
    logic       yellow_out;
    logic       green_out;
    logic       fault;
    logic [1:0] fault_code;

    int n_cmp = 0;
    int n_err = 0;

    traffic_lamp_guard #(
        .MIN_DWELL  (4),
        .FLASH_HALF (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .red_in      (red_in),
        .yellow_in   (yellow_in),
        .green_in    (green_in),
        .fault_clear (fault_clear),
        .red_out     (red_out),
        .yellow_out  (yellow_out),
        .green_out   (green_out),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Expected patterns {fault, code, r, y, g}.
    localparam logic [5:0] OK_R   = 6'b0_00_100;
    localparam logic [5:0] OK_Y   = 6'b0_00_010;
    localparam logic [5:0] OK_G   = 6'b0_00_001;
    localparam logic [5:0] F01_ON = 6'b1_01_010;
    localparam logic [5:0] F10_ON = 6'b1_10_010;
    localparam logic [5:0] F11_ON = 6'b1_11_010;
    localparam logic [5:0] F11_OF = 6'b1_11_000;

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (fault,code,r,y,g)", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] obs();
        return {fault, fault_code, red_out, yellow_out, green_out};
    endfunction

    // Apply one cycle of inputs; return 1 time unit after the capturing edge.
    task automatic step(input logic r, input logic y, input logic g, input logic clr);
        red_in      = r;
        yellow_in   = y;
        green_in    = g;
        fault_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check_eq("reset_state", obs(), OK_R);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b1;
        red_in      = 1'b1;
        yellow_in   = 1'b0;
        green_in    = 1'b0;
        fault_clear = 1'b0;
        #2;
        do_reset();

        // Legal R(4) -> G(4) -> Y(4) -> R cycle
        for (int i = 0; i < 4; i++) begin step(1'b1, 1'b0, 1'b0, 1'b0); check_eq("t1_red",    obs(), OK_R); end
        for (int i = 0; i < 4; i++) begin step(1'b0, 1'b0, 1'b1, 1'b0); check_eq("t1_green",  obs(), OK_G); end
        for (int i = 0; i < 4; i++) begin step(1'b0, 1'b1, 1'b0, 1'b0); check_eq("t1_yellow", obs(), OK_Y); end
        for (int i = 0; i < 4; i++) begin step(1'b1, 1'b0, 1'b0, 1'b0); check_eq("t1_red2",   obs(), OK_R); end

        // Early G->Y gives a dwell violation
        step(1'b0, 1'b0, 1'b1, 1'b0); check_eq("t2_g1", obs(), OK_G);
        step(1'b0, 1'b0, 1'b1, 1'b0); check_eq("t2_g2", obs(), OK_G);
        step(1'b0, 1'b1, 1'b0, 1'b0); check_eq("t2_dwell", obs(), F11_ON);

        // Flashing continues 1,1,(entry) 1,0,0,0,1; violations ignored in FAULT
        step(1'b1, 1'b0, 1'b1, 1'b0); check_eq("t4_fl1", obs(), F11_ON);
        step(1'b0, 1'b1, 1'b0, 1'b0); check_eq("t4_fl2", obs(), F11_ON);
        step(1'b0, 1'b1, 1'b0, 1'b0); check_eq("t4_fl3", obs(), F11_OF);
        step(1'b0, 1'b1, 1'b0, 1'b0); check_eq("t4_fl4", obs(), F11_OF);
        step(1'b0, 1'b1, 1'b0, 1'b0); check_eq("t4_fl5", obs(), F11_OF);
        step(1'b0, 1'b1, 1'b0, 1'b0); check_eq("t4_fl6", obs(), F11_ON);
        // Clear while requesting yellow is ignored
        step(1'b0, 1'b1, 1'b0, 1'b1); check_eq("t4_clr_ylw", obs(), F11_ON);
        // Clear while requesting red starts recovery
        step(1'b1, 1'b0, 1'b0, 1'b1); check_eq("t4_rec1", obs(), OK_R);
        step(1'b1, 1'b0, 1'b0, 1'b0); check_eq("t4_rec2", obs(), OK_R);
        step(1'b1, 1'b0, 1'b0, 1'b0); check_eq("t4_rec3", obs(), OK_R);
        step(1'b1, 1'b0, 1'b0, 1'b0); check_eq("t4_rec4", obs(), OK_R);
        step(1'b1, 1'b0, 1'b0, 1'b0); check_eq("t4_normal", obs(), OK_R);
        // Back in NORMAL with full dwell: R->G is legal immediately
        step(1'b0, 1'b0, 1'b1, 1'b0); check_eq("t4_first_g", obs(), OK_G);

        // Red and green requested together give a bad pattern
        step(1'b1, 1'b0, 1'b1, 1'b0); check_eq("t3_pattern", obs(), F01_ON);
        step(1'b0, 1'b1, 1'b0, 1'b0); check_eq("t3_code_hold", obs(), F01_ON);

        // After reset, G for 4 cycles, then a direct step to R gives a bad sequence
        do_reset();
        for (int i = 0; i < 4; i++) begin step(1'b0, 1'b0, 1'b1, 1'b0); check_eq("t3_green", obs(), OK_G); end
        step(1'b1, 1'b0, 1'b0, 1'b0); check_eq("t3_sequence", obs(), F10_ON);

        // Dropping red during the second recovery cycle faults with code 11
        step(1'b1, 1'b0, 1'b0, 1'b1); check_eq("t5_rec1", obs(), OK_R);
        step(1'b1, 1'b0, 1'b0, 1'b0); check_eq("t5_rec2", obs(), OK_R);
        step(1'b0, 1'b0, 1'b0, 1'b0); check_eq("t5_drop", obs(), F11_ON);
        step(1'b0, 1'b0, 1'b0, 1'b0); check_eq("t5_flash", obs(), F11_ON);
        step(1'b0, 1'b0, 1'b0, 1'b0); check_eq("t5_flash3", obs(), F11_ON);
        step(1'b0, 1'b0, 1'b0, 1'b0); check_eq("t5_flash_off", obs(), F11_OF);

        // Asynchronous reset in mid-flash, then a legal R->G with no dwell fault
        red_in = 1'b1; yellow_in = 1'b0; green_in = 1'b0;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1); check_eq("t6_first_g_clr", obs(), OK_G);
        step(1'b0, 1'b0, 1'b1, 1'b0); check_eq("t6_g_hold", obs(), OK_G);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
